// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uartWrite byte transmitter between NREQ requesters.
// Round-robin arbitration picks one owner. That owner keeps the transmitter
// for its whole packet. Each byte goes through a run/feedback handshake, and
// the owner receives a one-cycle ack for every byte sent. A watchdog aborts any
// handshake that stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_run,
  input  logic              tx_feedback,
  output logic              timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SEND,
    ACK,
    NEXT
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic             last_q;
  logic [CW-1:0]    wd_cnt;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [NREQ-1:0]  win_onehot;
  logic             wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);

  // Round-robin search: first active request at or after rr_ptr+1, wrapping.
  always_comb begin
    int            cand;
    logic [IW-1:0] cidx;
    win_vld    = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    cidx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      cidx = IW'(cand);
      if (!win_vld && req[cidx]) begin
        win_vld = 1'b1;
        win_idx = cidx;
      end
    end
    if (win_vld) begin
      win_onehot = NREQ'(1) << win_idx;
    end
  end

  // Transfer FSM. It handles arbitration, the per-byte run/feedback handshake,
  // packet locking and the watchdog abort. All outputs are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      tx_data     <= '0;
      tx_run      <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      rr_ptr      <= PTR_INIT;
      owner       <= '0;
      last_q      <= 1'b0;
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          tx_run <= 1'b0;
          if (win_vld) begin
            grant   <= win_onehot;
            busy    <= 1'b1;
            owner   <= win_idx;
            tx_data <= data_in[8*win_idx +: 8];
            last_q  <= last[win_idx];
            state   <= CLR;
          end
        end

        // Wait for the transmitter to re-arm (feedback low) before starting the byte.
        CLR: begin
          if (!tx_feedback) begin
            tx_run <= 1'b1;
            wd_cnt <= '0;
            state  <= SEND;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            busy        <= 1'b0;
            tx_run      <= 1'b0;
            rr_ptr      <= owner;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        // Byte in flight: hold run and data until the transmitter reports it sent.
        SEND: begin
          if (tx_feedback) begin
            ack    <= grant;
            wd_cnt <= '0;
            state  <= ACK;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            busy        <= 1'b0;
            tx_run      <= 1'b0;
            rr_ptr      <= owner;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        // The ack pulse is visible during this cycle. The owner advances its byte now.
        ACK: begin
          wd_cnt <= '0;
          state  <= NEXT;
        end

        // End of packet releases the transmitter. Otherwise load the owner's next byte.
        NEXT: begin
          wd_cnt <= '0;
          tx_run <= 1'b0;
          if (last_q || !req[owner]) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= owner;
            state  <= IDLE;
          end else begin
            tx_data <= data_in[8*owner +: 8];
            last_q  <= last[owner];
            state   <= CLR;
          end
        end

        default: begin
          grant  <= '0;
          busy   <= 1'b0;
          tx_run <= 1'b0;
          wd_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
